// File: rtl/iter_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iter_shifter_pkg
// Brief    : Op encodings and FSM state type shared by the iterative shifter.
// Revision : 1.0 - initial release
// ============================================================================
package iter_shifter_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : iter_shifter_pkg
`default_nettype wire

// File: rtl/iter_shifter_if.sv
`default_nettype none
// ============================================================================
// Module   : iter_shifter_if
// Brief    : Request/result bundle between the EX stage and the shifter.
// Revision : 1.0 - initial release
// ============================================================================
interface iter_shifter_if #(
    parameter int WIDTH = 32
) ();
    localparam int SHW = $clog2(WIDTH);

    logic             start_i;
    logic             flush_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] data_i;
    logic [SHW-1:0]   shamt_i;
    logic             busy_o;
    logic             valid_o;
    logic [WIDTH-1:0] data_o;

    modport master (
        output start_i, flush_i, op_i, data_i, shamt_i,
        input  busy_o, valid_o, data_o
    );

    modport slave (
        input  start_i, flush_i, op_i, data_i, shamt_i,
        output busy_o, valid_o, data_o
    );

endinterface : iter_shifter_if
`default_nettype wire

// File: rtl/iter_shifter_shift_step.sv
`default_nettype none
// ============================================================================
// Module   : iter_shifter_shift_step
// Brief    : Combinational single-step shifter, 0..STEP positions, four ops.
// Revision : 1.0 - initial release
// ============================================================================
module iter_shifter_shift_step
    import iter_shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic [WIDTH-1:0]       data_i,
    input  logic [1:0]             op_i,
    input  logic [$clog2(STEP):0]  amt_i,
    input  logic                   fill_i,
    output logic [WIDTH-1:0]       data_o
);
    localparam int RW = $clog2(WIDTH) + 1;

    logic [RW-1:0]    w_ramt;
    logic [WIDTH-1:0] w_fill_mask;

    // A right shift by WIDTH-amt supplies the wrapped bits for the rotate;
    // with amt=0 that shift clears everything, leaving the operand intact.
    assign w_ramt      = RW'(WIDTH) - RW'(amt_i);
    assign w_fill_mask = ~({WIDTH{1'b1}} >> amt_i);

    always_comb begin
        data_o = data_i;
        case (op_i)
            OP_SLL:  data_o = data_i << amt_i;
            OP_SRL:  data_o = data_i >> amt_i;
            OP_SRA:  data_o = (data_i >> amt_i) | (fill_i ? w_fill_mask : '0);
            OP_ROL:  data_o = (data_i << amt_i) | (data_i >> w_ramt);
            default: data_o = data_i;
        endcase
    end

endmodule : iter_shifter_shift_step
`default_nettype wire

// File: rtl/iter_shifter.sv
`default_nettype none
// ============================================================================
// Module   : iter_shifter
// Brief    : Multi-cycle SLL/SRL/SRA/ROL unit, at most STEP bits per clock.
// Revision : 1.0 - initial release
// ============================================================================
module iter_shifter
    import iter_shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    iter_shifter_if.slave bus
);
    localparam int SHW  = $clog2(WIDTH);
    localparam int CNTW = SHW + 1;
    localparam int AMTW = $clog2(STEP) + 1;

    localparam logic [CNTW-1:0] c_step = CNTW'(STEP);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] w_work_next;
    logic [WIDTH-1:0] w_step_out;
    logic [WIDTH-1:0] r_data;
    logic [1:0]       r_op;
    logic             r_fill;
    logic [CNTW-1:0]  r_rem;
    logic [CNTW-1:0]  w_rem_next;
    logic [CNTW-1:0]  w_rem_after;
    logic [AMTW-1:0]  w_amt;
    logic             w_accept;
    logic             r_busy;
    logic             r_valid;

    assign w_amt       = (r_rem > c_step) ? AMTW'(STEP) : r_rem[AMTW-1:0];
    assign w_rem_after = r_rem - CNTW'(w_amt);
    assign w_accept    = bus.start_i && !bus.flush_i &&
                         ((r_state == ST_IDLE) || (r_state == ST_DONE));

    iter_shifter_shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .data_i (r_work),
        .op_i   (r_op),
        .amt_i  (w_amt),
        .fill_i (r_fill),
        .data_o (w_step_out)
    );

    always_comb begin
        w_next_state = r_state;
        w_work_next  = r_work;
        w_rem_next   = r_rem;
        case (r_state)
            ST_IDLE:  w_next_state = ST_IDLE;
            ST_DONE:  w_next_state = ST_IDLE;
            ST_SHIFT: begin
                w_work_next = w_step_out;
                w_rem_next  = w_rem_after;
                if (w_rem_after == '0) begin
                    w_next_state = ST_DONE;
                end
            end
            default:  w_next_state = ST_IDLE;
        endcase
        if (w_accept) begin
            w_work_next  = bus.data_i;
            w_rem_next   = CNTW'(bus.shamt_i);
            w_next_state = (bus.shamt_i == '0) ? ST_DONE : ST_SHIFT;
        end
        // Abort wins over everything except reset; results stay untouched.
        if (bus.flush_i) begin
            w_next_state = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_work  <= '0;
            r_rem   <= '0;
            r_op    <= OP_SLL;
            r_fill  <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_next_state;
            r_work  <= w_work_next;
            r_rem   <= w_rem_next;
            if (w_accept) begin
                r_op   <= bus.op_i;
                r_fill <= bus.data_i[WIDTH-1];
            end
            // Outputs are registered from the next state so they line up
            // exactly with the cycles spent in SHIFT and DONE.
            r_busy  <= (w_next_state == ST_SHIFT);
            r_valid <= (w_next_state == ST_DONE);
            if (w_next_state == ST_DONE) begin
                r_data <= w_work_next;
            end
        end
    end

    assign bus.busy_o  = r_busy;
    assign bus.valid_o = r_valid;
    assign bus.data_o  = r_data;

endmodule : iter_shifter
`default_nettype wire

// File: doc/iter_shifter.md
# iter_shifter

Parametrised multi-cycle shift unit for the pipelined CPU datapath. It generalises the fixed one-bit left shift used for branch offsets into four operations: SLL, SRL, SRA and ROL. It handles any shift amount and processes at most STEP bit positions per clock. The EX stage drives it through a start/valid handshake and stalls on busy_o, trading cycles for a small shifter.

## Interface
- WIDTH, 32, data width; power of two, >= 8
- STEP, 4, max bit positions shifted per cycle; power of two, 1..WIDTH
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-low
- start_i  in  1  request; accepted when state is IDLE or DONE
- flush_i  in  1  synchronous abort of the in-flight operation
- op_i  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL
- data_i  in  WIDTH  operand
- shamt_i  in  log2(WIDTH)  shift amount, unsigned
- busy_o  out  1  high while in SHIFT; start_i is ignored when high
- valid_o  out  1  one-cycle pulse, result on data_o
- data_o  out  WIDTH  result; held until the next accepted start

## Operation
- States: IDLE, SHIFT, DONE.
- Accept: start_i=1 in IDLE or DONE, with flush_i=0.
  - Latch data_i, op_i and shamt_i into the working register, op register and remaining counter.
  - If shamt_i=0, go to DONE; otherwise go to SHIFT.
- SHIFT, each cycle:
  - amt = min(STEP, remaining).
  - work <= work shifted by amt per op; remaining <= remaining - amt.
  - Go to DONE when remaining - amt = 0.
- Shift semantics per op:
  - SLL and SRL zero-fill.
  - SRA fills with the latched operand's bit WIDTH-1.
  - ROL wraps bits out of the MSB into the LSB.
- DONE:
  - data_o <= work and valid_o=1 for exactly one cycle.
  - Next state is IDLE, or a new accept (back-to-back).
- IDLE without start_i: hold, valid_o=0.
- start_i during SHIFT: ignored. There is no queue, and the in-flight operation is unaffected.
- flush_i=1 in any state:
  - Next state IDLE, valid_o=0 next cycle, data_o unchanged.
  - flush_i has priority over start_i in the same cycle.
- rst_i=0 (highest priority), mid-operation included:
  - state IDLE, busy_o 0, valid_o 0, data_o 0, remaining 0, work 0.
- Width rule: the remaining counter is log2(WIDTH)+1 bits wide, so a full-range shamt never wraps. All shifts are logical on WIDTH bits, with no overflow flag.

## Timing
- Latency from the accept edge to the valid_o cycle is ceil(shamt/STEP)+1 cycles.
  - shamt=0: 1 cycle.
  - WIDTH=32, STEP=4, shamt=31: 9 cycles.
- Throughput: one op per latency. A back-to-back accept in DONE adds no idle cycle.
- busy_o is registered: high exactly for the cycles the state is SHIFT, low in IDLE and DONE.
- data_o and valid_o are registered outputs. data_o changes only in the cycle valid_o is high, or on reset.
- STEP=WIDTH: every nonzero shamt takes exactly one SHIFT cycle, latency 2.

## Structure
- Package iter_shifter_pkg holds:
  - op encodings OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROL=2'b11;
  - the state type (IDLE, SHIFT, DONE).
- Sub-module shift_step:
  - combinational single-step shifter of WIDTH bits by amt in 0..STEP for all four ops, plus a fill-bit input;
  - instantiated once in the SHIFT datapath.
- The top level holds the FSM, the remaining counter and the output registers.

## Test plan
All scenarios use WIDTH=32, STEP=4.
- Reset: hold rst_i=0 for 2 cycles with random inputs -> busy_o=0, valid_o=0, data_o=0x00000000. After release, IDLE with no spurious valid_o.
- Branch-offset case: SLL 0x00000001, shamt 1 -> valid_o 2 cycles after accept, data_o=0x00000002. busy_o high for exactly 1 cycle.
- Full-range right shifts:
  - SRA 0x80000000, shamt 31 -> data_o=0xFFFFFFFF after 9 cycles.
  - SRL with the same operands -> data_o=0x00000001.
- Rotate and zero shift:
  - ROL 0x80000001, shamt 4 -> 0x00000018, latency 2.
  - SLL 0x12345678, shamt 0 -> 0x12345678, latency 1.
- Handshake:
  - start_i pulsed during SHIFT -> ignored, first result unchanged.
  - start_i held in DONE -> second op accepted with no gap cycle, two valid_o pulses.
- Abort:
  - flush_i at cycle 3 of a shamt-31 op -> IDLE next cycle, no valid_o, previous data_o retained.
  - rst_i=0 at the same point -> data_o=0, no valid_o.
